keyboard_ctrl: RTL and testbench

PS/2 keyboard front end that produces the four held-direction level signals `ctrl_up`, `ctrl_down`, `ctrl_left` and `ctrl_right` consumed by the player movement logic. It synchronizes and filters the PS/2 clock and data lines, deframes 11-bit device-to-host frames, and decodes scan-code set 2 make/break sequences (including `E0`-prefixed arrow keys). Each output stays high for as long as its key is held. It sits between the board PS/2 pins and the game logic, in the same system clock domain.

---
 rtl/keyboard_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_keyboard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_ctrl.sv
// keyboard_ctrl: PS/2 keyboard front end producing held-direction levels.
//
// The block synchronizes the PS/2 clock and data pins and filters the clock line.
// It deframes 11-bit device-to-host frames and decodes scan-code set 2 make/break
// sequences, including E0-prefixed arrow keys.
//
// Optional feature macro: KBD_PARITY_CHECK_EN
//   defined     - a frame is accepted only with stop=1 and odd parity.
//   not defined - the parity bit is ignored and only the stop bit is checked.
//
// Parameters:
//   FILTER_LEN     consecutive synchronized samples needed to accept a PS/2 clock change
//   TIMEOUT_CYCLES idle cycles between PS/2 clock falls, mid-frame, before the frame aborts
// Ports:
//   clk        system clock
//   reset      asynchronous reset, active low
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   ps2_data   raw PS/2 data pin (asynchronous)
//   ctrl_up    high while W or Up-arrow is held
//   ctrl_down  high while S or Down-arrow is held
//   ctrl_left  high while A or Left-arrow is held
//   ctrl_right high while D or Right-arrow is held
//   scan_code  last accepted data byte
//   scan_valid one-cycle pulse when scan_code updates
//   frame_err  one-cycle pulse when a frame is dropped
module keyboard_ctrl #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ctrl_up,
    output logic       ctrl_down,
    output logic       ctrl_left,
    output logic       ctrl_right,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int unsigned FiltW    = $clog2(FILTER_LEN + 1);
    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // ---------------------------------------------------------------- input conditioning
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_s;
    logic       data_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             filt_clk_q, filt_clk_d;
    logic             fall;

    // Count consecutive samples that disagree with the filtered level; any agreeing
    // sample restarts the count, so short glitches never reach the threshold.
    always_comb begin
        filt_cnt_d = '0;
        filt_clk_d = filt_clk_q;
        fall       = 1'b0;
        if (clk_s != filt_clk_q) begin
            if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_s;
                fall       = ~clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_cnt_q <= '0;
            filt_clk_q <= 1'b1;
        end else begin
            filt_cnt_q <= filt_cnt_d;
            filt_clk_q <= filt_clk_d;
        end
    end

    // ---------------------------------------------------------------- deframer
    state_e              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;
    logic                stop_ok;
    logic                accept;
    logic                err;

`ifdef KBD_PARITY_CHECK_EN
    logic par_q, par_d;
    assign stop_ok = data_s & (^{shift_q, par_q});
`else
    assign stop_ok = data_s;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef KBD_PARITY_CHECK_EN
        par_d     = par_q;
`endif
        accept    = 1'b0;
        err       = 1'b0;

        // Held at zero in idle, so it only measures gaps inside a frame.
        if (fall || state_q == StIdle) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (fall) begin
            case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
                StData: begin
                    shift_d = {data_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                StParity: begin
`ifdef KBD_PARITY_CHECK_EN
                    par_d   = data_s;
`endif
                    state_d = StStop;
                end
                StStop: begin
                    if (stop_ok) begin
                        accept = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && to_cnt_q == TimeoutW'(TIMEOUT_CYCLES)) begin
            state_d = StIdle;
            err     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            to_cnt_q  <= '0;
`ifdef KBD_PARITY_CHECK_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            to_cnt_q  <= to_cnt_d;
`ifdef KBD_PARITY_CHECK_EN
            par_q     <= par_d;
`endif
        end
    end

    // ---------------------------------------------------------------- decoder
    // Held bits are indexed {right, left, down, up}; letter keys and arrows are kept
    // apart so that releasing one source leaves the other holding the direction.
    logic [3:0] kbd_q, kbd_d;
    logic [3:0] arr_q, arr_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [7:0] scan_code_q;
    logic       scan_valid_q;
    logic       frame_err_q;

    always_comb begin
        kbd_d = kbd_q;
        arr_d = arr_q;
        ext_d = ext_q;
        brk_d = brk_q;
        if (accept) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (!ext_q) begin
                    case (shift_q)
                        8'h1D:   kbd_d[0] = ~brk_q;
                        8'h1B:   kbd_d[1] = ~brk_q;
                        8'h1C:   kbd_d[2] = ~brk_q;
                        8'h23:   kbd_d[3] = ~brk_q;
                        default: ;
                    endcase
                end else begin
                    case (shift_q)
                        8'h75:   arr_d[0] = ~brk_q;
                        8'h72:   arr_d[1] = ~brk_q;
                        8'h6B:   arr_d[2] = ~brk_q;
                        8'h74:   arr_d[3] = ~brk_q;
                        default: ;
                    endcase
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbd_q        <= '0;
            arr_q        <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            scan_code_q  <= '0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            kbd_q        <= kbd_d;
            arr_q        <= arr_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            scan_valid_q <= accept;
            frame_err_q  <= err;
            if (accept) begin
                scan_code_q <= shift_q;
            end
        end
    end

    assign ctrl_up    = kbd_q[0] | arr_q[0];
    assign ctrl_down  = kbd_q[1] | arr_q[1];
    assign ctrl_left  = kbd_q[2] | arr_q[2];
    assign ctrl_right = kbd_q[3] | arr_q[3];
    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_keyboard_ctrl.sv
// Self-checking bench for keyboard_ctrl: table-driven frames, hand-written corner
// sequences (bad start, timeout, clock glitch, mid-frame reset) and random frames
// checked against a key-state model.
module tb_keyboard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ctrl_up, ctrl_down, ctrl_left, ctrl_right;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    always #5 clk = ~clk;

    keyboard_ctrl #(
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ctrl_up   (ctrl_up),
        .ctrl_down (ctrl_down),
        .ctrl_left (ctrl_left),
        .ctrl_right(ctrl_right),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .frame_err (frame_err)
    );

`ifdef KBD_PARITY_CHECK_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    // Frame kinds
    localparam int KGood = 0;
    localparam int KBadPar = 1;
    localparam int KBadStop = 2;

    typedef struct {
        logic [7:0] code;
        int         kind;
        logic [3:0] exp_ctrl;  // {right, left, down, up}
        bit         exp_valid;
        bit         exp_err;
    } vec_t;

    vec_t vecs[$];

    int n_total = 0;
    int n_pass  = 0;

    // Output-event monitor, sampled away from the active edge
    int         sv_cnt = 0;
    int         fe_cnt = 0;
    logic [7:0] last_code = 8'h00;

    always @(negedge clk) begin
        if (scan_valid) begin
            sv_cnt++;
            last_code = scan_code;
        end
        if (frame_err) fe_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [3:0] ctrl_vec();
        return {ctrl_right, ctrl_left, ctrl_down, ctrl_up};
    endfunction

    // ---------------------------------------------------------------- reference model
    logic [7:0] letters[4];
    logic [7:0] arrows[4];
    bit         held[4][2];  // [direction][0 = letter key, 1 = arrow key]
    bit         m_ext, m_brk;

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            held[d][0] = 1'b0;
            held[d][1] = 1'b0;
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            for (int d = 0; d < 4; d++) begin
                if (!m_ext && b == letters[d]) held[d][0] = !m_brk;
                if (m_ext && b == arrows[d]) held[d][1] = !m_brk;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    function automatic logic [3:0] model_ctrl();
        logic [3:0] r;
        for (int d = 0; d < 4; d++) r[d] = held[d][0] | held[d][1];
        return r;
    endfunction

    // ---------------------------------------------------------------- PS/2 driver
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 20-cycle bit: data set while clock high, clock low for 10 cycles.
    // An optional 2-cycle low glitch is placed in the leading high phase.
    task automatic ps2_bit(input logic d, input bit glitch);
        ps2_data = d;
        wait_cycles(1);
        if (glitch) begin
            ps2_clk = 1'b0;
            wait_cycles(2);
            ps2_clk = 1'b1;
            wait_cycles(2);
        end else begin
            wait_cycles(4);
        end
        ps2_clk = 1'b0;
        wait_cycles(10);
        ps2_clk = 1'b1;
        wait_cycles(5);
    endtask

    task automatic send_frame(input logic [7:0] b, input int kind, input int nbits,
                              input int glitch_at);
        logic bits[11];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        bits[9]  = (~^b) ^ (kind == KBadPar);
        bits[10] = (kind == KBadStop) ? 1'b0 : 1'b1;
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i], i == glitch_at);
        ps2_data = 1'b1;
        wait_cycles(12);
    endtask

    task automatic frame_check(input string name, input logic [7:0] b, input int kind,
                               input int glitch_at, input bit exp_valid, input bit exp_err,
                               input logic [3:0] exp_ctrl);
        int sv0, fe0;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_frame(b, kind, 11, glitch_at);
        check({name, " scan_valid count"}, sv_cnt - sv0, 32'(exp_valid));
        check({name, " frame_err count"}, fe_cnt - fe0, 32'(exp_err));
        if (exp_valid) check({name, " scan_code"}, last_code, b);
        check({name, " ctrl"}, ctrl_vec(), exp_ctrl);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " ctrl"}, ctrl_vec(), 4'b0000);
        check({name, " scan_code"}, scan_code, 8'h00);
        check({name, " scan_valid"}, scan_valid, 1'b0);
        check({name, " frame_err"}, frame_err, 1'b0);
    endtask

    // ---------------------------------------------------------------- test sequence
    initial begin
        int sv0, fe0;
        letters = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
        arrows  = '{8'h75, 8'h72, 8'h6B, 8'h74};
        model_reset();

        vecs.push_back('{8'h1D, KGood, 4'b0001, 1'b1, 1'b0});
        vecs.push_back('{8'hF0, KGood, 4'b0001, 1'b1, 1'b0});
        vecs.push_back('{8'h1D, KGood, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{8'hE0, KGood, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{8'h6B, KGood, 4'b0100, 1'b1, 1'b0});
        vecs.push_back('{8'hE0, KGood, 4'b0100, 1'b1, 1'b0});
        vecs.push_back('{8'hF0, KGood, 4'b0100, 1'b1, 1'b0});
        vecs.push_back('{8'h6B, KGood, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{8'h6B, KGood, 4'b0000, 1'b1, 1'b0});  // plain 6B: unmapped
        vecs.push_back('{8'h1D, KGood, 4'b0001, 1'b1, 1'b0});
        vecs.push_back('{8'hE0, KGood, 4'b0001, 1'b1, 1'b0});
        vecs.push_back('{8'h75, KGood, 4'b0001, 1'b1, 1'b0});
        vecs.push_back('{8'hF0, KGood, 4'b0001, 1'b1, 1'b0});
        vecs.push_back('{8'h1D, KGood, 4'b0001, 1'b1, 1'b0});  // arrow still holds up
        vecs.push_back('{8'hE0, KGood, 4'b0001, 1'b1, 1'b0});
        vecs.push_back('{8'hF0, KGood, 4'b0001, 1'b1, 1'b0});
        vecs.push_back('{8'h75, KGood, 4'b0000, 1'b1, 1'b0});
`ifdef KBD_PARITY_CHECK_EN
        vecs.push_back('{8'h23, KBadPar, 4'b0000, 1'b0, 1'b1});
        vecs.push_back('{8'hF0, KGood, 4'b0000, 1'b1, 1'b0});
`else
        vecs.push_back('{8'h23, KBadPar, 4'b1000, 1'b1, 1'b0});
        vecs.push_back('{8'hF0, KGood, 4'b1000, 1'b1, 1'b0});
`endif
        vecs.push_back('{8'h23, KGood, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{8'h1B, KBadStop, 4'b0000, 1'b0, 1'b1});
        vecs.push_back('{8'h1B, KGood, 4'b0010, 1'b1, 1'b0});
        vecs.push_back('{8'h1B, KGood, 4'b0010, 1'b1, 1'b0});  // typematic repeat
        vecs.push_back('{8'hF0, KGood, 4'b0010, 1'b1, 1'b0});
        vecs.push_back('{8'h1B, KGood, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{8'hE0, KGood, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{8'h72, KBadStop, 4'b0000, 1'b0, 1'b1});  // drop keeps ext
        vecs.push_back('{8'h72, KGood, 4'b0010, 1'b1, 1'b0});
        vecs.push_back('{8'hE0, KGood, 4'b0010, 1'b1, 1'b0});
        vecs.push_back('{8'hF0, KGood, 4'b0010, 1'b1, 1'b0});
        vecs.push_back('{8'h72, KGood, 4'b0000, 1'b1, 1'b0});

        // Reset state
        wait_cycles(3);
        check_all_zero("reset");
        reset = 1'b1;
        wait_cycles(5);

        // Table
        foreach (vecs[i]) begin
            frame_check($sformatf("vec%0d", i), vecs[i].code, vecs[i].kind, -1,
                        vecs[i].exp_valid, vecs[i].exp_err, vecs[i].exp_ctrl);
        end

        // Start bit of 1 is rejected, then reception proceeds normally
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        ps2_bit(1'b1, 1'b0);
        wait_cycles(12);
        check("bad start frame_err count", fe_cnt - fe0, 1);
        check("bad start scan_valid count", sv_cnt - sv0, 0);
        frame_check("after bad start 1C", 8'h1C, KGood, -1, 1'b1, 1'b0, 4'b0100);
        frame_check("release F0", 8'hF0, KGood, -1, 1'b1, 1'b0, 4'b0100);
        frame_check("release 1C", 8'h1C, KGood, -1, 1'b1, 1'b0, 4'b0000);

        // Timeout: 5 bits then a 250-cycle stall; only one error, none while idle
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h1B, KGood, 5, -1);
        wait_cycles(250);
        check("timeout frame_err count", fe_cnt - fe0, 1);
        check("timeout scan_valid count", sv_cnt - sv0, 0);
        check("timeout ctrl", ctrl_vec(), 4'b0000);
        frame_check("after timeout 1B", 8'h1B, KGood, -1, 1'b1, 1'b0, 4'b0010);
        frame_check("release F0", 8'hF0, KGood, -1, 1'b1, 1'b0, 4'b0010);
        frame_check("release 1B", 8'h1B, KGood, -1, 1'b1, 1'b0, 4'b0000);

        // 2-cycle clock glitch inside a data bit must not shift an extra bit
        frame_check("glitch 23", 8'h23, KGood, 3, 1'b1, 1'b0, 4'b1000);
        frame_check("glitch 23 break F0", 8'hF0, KGood, 7, 1'b1, 1'b0, 4'b1000);
        frame_check("glitch 23 break", 8'h23, KGood, -1, 1'b1, 1'b0, 4'b0000);

        // Reset asserted mid-frame clears everything at once, reception then restarts
        frame_check("pre-reset 1D", 8'h1D, KGood, -1, 1'b1, 1'b0, 4'b0001);
        send_frame(8'h75, KGood, 6, -1);
        reset = 1'b0;
        #1;
        check_all_zero("mid-frame reset");
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(5);
        frame_check("post-reset 1C", 8'h1C, KGood, -1, 1'b1, 1'b0, 4'b0100);
        frame_check("post-reset F0", 8'hF0, KGood, -1, 1'b1, 1'b0, 4'b0100);
        frame_check("post-reset 1C break", 8'h1C, KGood, -1, 1'b1, 1'b0, 4'b0000);

        // Random frames against the model, starting from a clean reset
        reset = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(5);
        model_reset();
        for (int n = 0; n < 80; n++) begin
            logic [7:0] b;
            int         sel, r, kind;
            bit         ok;
            logic [7:0] pool[10];
            pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0};
            sel = $urandom_range(0, 11);
            b = (sel < 10) ? pool[sel] : 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            kind = (r == 0) ? KBadPar : (r == 1) ? KBadStop : KGood;
            ok = (kind != KBadStop) && (kind != KBadPar || !ParEn);
            if (ok) model_byte(b);
            frame_check($sformatf("rand%0d", n), b, kind, -1, ok, !ok, model_ctrl());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
